// File: rtl/data_mem_responder.sv
// Multi-cycle data memory target: accepts one request, stalls for LATENCY edges,
// then completes it with a one-cycle done pulse and registered read data.
module data_mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        stall,
    output logic        done,
    output logic        err
);

    localparam int          WORDS   = 2 ** DEPTH_LOG2;
    localparam logic [3:0]  LAT_CNT = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                state_q;
    logic [3:0]            count_q;
    logic                  wr_q;
    logic [DEPTH_LOG2:0]   addr_q;
    logic [15:0]           data_q;
    logic [15:0]           data_out_q;
    logic                  err_q;
    logic [15:0]           mem_q [WORDS];

    logic                  acceptReq;
    logic                  accessNow;
    logic                  misaligned;
    logic [DEPTH_LOG2-1:0] wordIdx;
    logic                  unused_addr_bits;

    // Upper address bits only alias the array, so they are deliberately dropped.
    assign unused_addr_bits = ^addr[15:DEPTH_LOG2+1];

    assign acceptReq  = enable && ((state_q == IDLE) || (state_q == RESP));
    assign accessNow  = (state_q == BUSY) && (count_q == 4'd1);
    assign misaligned = addr_q[0];
    assign wordIdx    = addr_q[DEPTH_LOG2:1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= 4'd0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= 16'd0;
            data_out_q <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            if (acceptReq) begin
                wr_q    <= wr;
                addr_q  <= addr[DEPTH_LOG2:0];
                data_q  <= data_in;
                count_q <= LAT_CNT;
                state_q <= BUSY;
            end
            case (state_q)
                IDLE: begin
                end
                BUSY: begin
                    count_q <= count_q - 4'd1;
                    if (count_q == 4'd1) begin
                        state_q <= RESP;
                        err_q   <= misaligned;
                        if (!misaligned && !wr_q) begin
                            data_out_q <= mem_q[wordIdx];
                        end
                    end
                end
                RESP: begin
                    err_q <= 1'b0;
                    if (!enable) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The array keeps its contents across reset; a reset simply leaves BUSY before
    // the access edge, so an interrupted write never lands.
    always_ff @(posedge clk) begin
        if (accessNow && wr_q && !misaligned) begin
            mem_q[wordIdx] <= data_q;
        end
    end

    assign data_out = data_out_q;
    assign stall    = (state_q == BUSY);
    assign done     = (state_q == RESP);
    assign err      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised self-checking bench for data_mem_responder against a word-array model
// that applies the latency, alignment and wrap rules directly.
module tb_data_mem_responder;

    localparam int LAT        = 2;
    localparam int DEPTH_LOG2 = 8;
    localparam int WORDS      = 2 ** DEPTH_LOG2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = 16'd0;
    logic [15:0] data_in = 16'd0;
    logic [15:0] data_out;
    logic        stall;
    logic        done;
    logic        err;

    int          checksTotal = 0;
    int          checksPassed = 0;
    logic [15:0] modelMem [WORDS];
    logic [15:0] lastRead = 16'd0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .LATENCY   (LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .wr      (wr),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .stall   (stall),
        .done    (done),
        .err     (err)
    );

    function automatic int wordOf(input logic [15:0] a);
        return (int'(a) % (2 * WORDS)) / 2;
    endfunction

    // Called just after a negedge with the DUT in IDLE or RESP; returns just after
    // a negedge following the done cycle plus 'gap' idle cycles.
    task automatic do_request(input string tag, input logic w, input logic [15:0] a,
                              input logic [15:0] d, input int gap);
        logic        expErr;
        logic [15:0] expData;
        enable  = 1'b1;
        wr      = w;
        addr    = a;
        data_in = d;
        @(negedge clk);
        enable  = 1'($urandom);
        wr      = 1'($urandom);
        addr    = 16'($urandom);
        data_in = 16'($urandom);
        for (int k = 0; k < LAT; k++) begin
            checksTotal++;
            if (stall !== 1'b1 || done !== 1'b0 || err !== 1'b0 || data_out !== lastRead)
                $display("[TB] FAIL %s busy%0d: stall=%b done=%b err=%b data_out=%h, required stall=1 done=0 err=0 data_out=%h",
                         tag, k, stall, done, err, data_out, lastRead);
            else
                checksPassed++;
            @(negedge clk);
        end
        expErr = a[0];
        if (!a[0]) begin
            if (w) modelMem[wordOf(a)] = d;
            else   lastRead = modelMem[wordOf(a)];
        end
        expData = lastRead;
        checksTotal++;
        if (done !== 1'b1 || stall !== 1'b0 || err !== expErr || data_out !== expData)
            $display("[TB] FAIL %s done: done=%b stall=%b err=%b data_out=%h, required done=1 stall=0 err=%b data_out=%h",
                     tag, done, stall, err, data_out, expErr, expData);
        else
            checksPassed++;
        enable = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            checksTotal++;
            if (stall !== 1'b0 || done !== 1'b0 || err !== 1'b0 || data_out !== lastRead)
                $display("[TB] FAIL %s idle%0d: stall=%b done=%b err=%b data_out=%h, required 0 0 0 data_out=%h",
                         tag, g, stall, done, err, data_out, lastRead);
            else
                checksPassed++;
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        enable  = 1'b1;
        wr      = 1'b1;
        addr    = 16'h0010;
        data_in = 16'hFFFF;
        lastRead = 16'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checksTotal++;
            if (stall !== 1'b0 || done !== 1'b0 || err !== 1'b0 || data_out !== 16'd0)
                $display("[TB] FAIL reset%0d: stall=%b done=%b err=%b data_out=%h, required all zero",
                         i, stall, done, err, data_out);
            else
                checksPassed++;
        end
        rst = 1'b1;
    endtask

    task automatic test_write_read();
        do_request("wr_beef", 1'b1, 16'h0010, 16'hBEEF, 1);
        do_request("rd_beef", 1'b0, 16'h0010, 16'h0000, 1);
        checksTotal++;
        if (lastRead !== 16'hBEEF)
            $display("[TB] FAIL rd_beef_model: got %h, required BEEF", lastRead);
        else
            checksPassed++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < WORDS; i++)
            do_request("fill", 1'b1, {7'($urandom), 8'(i), 1'b0}, 16'($urandom),
                       (i == WORDS - 1) ? 1 : 0);
    endtask

    task automatic test_back_to_back();
        do_request("b2b_w2", 1'b1, 16'h0002, 16'h1357, 0);
        do_request("b2b_w4", 1'b1, 16'h0004, 16'h2468, 0);
        do_request("b2b_r2", 1'b0, 16'h0002, 16'h0000, 0);
        do_request("b2b_r4", 1'b0, 16'h0004, 16'h0000, 1);
    endtask

    task automatic test_misaligned();
        do_request("mis_pre",  1'b1, 16'h0020, 16'hA0A0, 1);
        do_request("mis_wr",   1'b1, 16'h0021, 16'h1234, 1);
        do_request("mis_rd",   1'b0, 16'h0020, 16'h0000, 1);
        do_request("mis_rdx",  1'b0, 16'h0023, 16'h0000, 1);
    endtask

    task automatic test_wrap();
        do_request("wrap_wr", 1'b1, 16'h0200, 16'h5A5A, 1);
        do_request("wrap_rd", 1'b0, 16'h0000, 16'h0000, 1);
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int i = 0; i < 80; i++) begin
            a = 16'($urandom);
            if ($urandom_range(7) != 0) a[0] = 1'b0;
            do_request("rand", 1'($urandom), a, 16'($urandom), $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid_busy();
        do_request("rmb_pre", 1'b1, 16'h0006, 16'h0F0F, 1);
        enable  = 1'b1;
        wr      = 1'b1;
        addr    = 16'h0006;
        data_in = 16'hFFFF;
        @(negedge clk);
        checksTotal++;
        if (stall !== 1'b1)
            $display("[TB] FAIL rmb_busy: stall=%b, required 1", stall);
        else
            checksPassed++;
        rst    = 1'b0;
        enable = 1'b0;
        lastRead = 16'd0;
        #1;
        checksTotal++;
        if (stall !== 1'b0 || done !== 1'b0 || err !== 1'b0 || data_out !== 16'd0)
            $display("[TB] FAIL rmb_reset: stall=%b done=%b err=%b data_out=%h, required all zero",
                     stall, done, err, data_out);
        else
            checksPassed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b1;
            checksTotal++;
            if (done !== 1'b0 || stall !== 1'b0)
                $display("[TB] FAIL rmb_nodone%0d: done=%b stall=%b, required 0 0", i, done, stall);
            else
                checksPassed++;
        end
        do_request("rmb_rd", 1'b0, 16'h0006, 16'h0000, 1);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fill();
        test_back_to_back();
        test_misaligned();
        test_wrap();
        test_random();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
